// File: rtl/hvac_pkg.sv
// Shared types and constants for the single-zone HVAC controller.
package hvac_pkg;

    typedef enum logic [2:0] {
        MODE_OFF       = 3'd0,
        MODE_AUTO      = 3'd1,
        MODE_FAST_COOL = 3'd2,
        MODE_ECO       = 3'd3,
        MODE_HEAT      = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        DEM_IDLE = 2'd0,
        DEM_COOL = 2'd1,
        DEM_HEAT = 2'd2
    } demand_t;

    // Upper |diff| bound of AUTO fan bands 1..3
    localparam int unsigned FAN_BAND1 = 3;
    localparam int unsigned FAN_BAND2 = 5;
    localparam int unsigned FAN_BAND3 = 7;

    // Mode button order; unreachable encodings fall back to OFF
    function automatic mode_t mode_next(input mode_t m);
        mode_t n;
        n = MODE_OFF;
        case (m)
            MODE_OFF:       n = MODE_AUTO;
            MODE_AUTO:      n = MODE_FAST_COOL;
            MODE_FAST_COOL: n = MODE_ECO;
            MODE_ECO:       n = MODE_HEAT;
            default:        n = MODE_OFF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/hvac_zone_ctrl_if.sv
// User/sensor inputs and actuator outputs of the zone controller.
interface hvac_zone_ctrl_if #(
    parameter int unsigned TEMP_W = 7,
    parameter int unsigned FAN_W  = 3
);
    logic              button_mode;
    logic              button_up;
    logic              button_down;
    logic [TEMP_W-1:0] temperature;
    logic [2:0]        mode;
    logic [TEMP_W-1:0] setpoint;
    logic [FAN_W-1:0]  fan_speed;
    logic              compressor_on;
    logic              heater_on;
    logic              lockout;

    modport master (
        output button_mode, button_up, button_down, temperature,
        input  mode, setpoint, fan_speed, compressor_on, heater_on, lockout
    );

    modport slave (
        input  button_mode, button_up, button_down, temperature,
        output mode, setpoint, fan_speed, compressor_on, heater_on, lockout
    );
endinterface

// File: rtl/hvac_fan_ramp.sv
// Fan level register that steps one level toward its target every RAMP_CYC cycles.
module hvac_fan_ramp #(
    parameter int unsigned FAN_W    = 3,
    parameter int unsigned RAMP_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [FAN_W-1:0] target,
    output logic [FAN_W-1:0] level
);
    localparam int unsigned CNT_W = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FAN_W-1:0] level_q, level_d;

    // Counter keeps running across target changes; only a match clears it
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (level_q == target) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(RAMP_CYC - 1)) begin
            cnt_d   = '0;
            level_d = (target > level_q) ? level_q + FAN_W'(1) : level_q - FAN_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/hvac_zone_ctrl.sv
// Single-zone climate controller: mode/setpoint buttons, cool/heat demand FSM, fan ramp.
// Optional HVAC_AUTO_REPEAT_EN adds hold-to-repeat on the setpoint buttons.
module hvac_zone_ctrl
    import hvac_pkg::*;
#(
    parameter int unsigned TEMP_W      = 7,
    parameter int unsigned SET_MIN     = 18,
    parameter int unsigned SET_MAX     = 26,
    parameter int unsigned SET_INIT    = 22,
    parameter int unsigned HYST        = 1,
    parameter int unsigned FAN_LEVELS  = 4,
    parameter int unsigned RAMP_CYC    = 4,
    parameter int unsigned MIN_OFF_CYC = 16
`ifdef HVAC_AUTO_REPEAT_EN
    , parameter int unsigned REPEAT_CYC = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    hvac_zone_ctrl_if.slave  bus
);
    localparam int unsigned FAN_W  = $clog2(FAN_LEVELS + 1);
    localparam int unsigned TMR_W  = $clog2(MIN_OFF_CYC + 1);
    localparam int          HYST_I = int'(HYST);

    mode_t             mode_q, mode_d;
    logic [TEMP_W-1:0] setpoint_q, setpoint_d;
    demand_t           state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              comp_q, comp_d;
    logic              heat_q, heat_d;
    logic              lock_q, lock_d;
    logic [2:0]        btn_q, btn_d;

    logic              mode_press_c, up_press_c, dn_press_c;
    logic              up_evt_c, dn_evt_c;
    logic signed [TEMP_W:0] diff_c;
    int                diff_i;
    int                mag_i;
    logic              cool_req_c, heat_req_c, cool_mode_c, heat_mode_c;
    int unsigned       fan_tgt_i;
    logic [FAN_W-1:0]  fan_tgt_c;
    logic [FAN_W-1:0]  fan_level;

    assign btn_d        = {bus.button_mode, bus.button_up, bus.button_down};
    assign mode_press_c = bus.button_mode & ~btn_q[2];
    assign up_press_c   = bus.button_up   & ~btn_q[1];
    assign dn_press_c   = bus.button_down & ~btn_q[0];

`ifdef HVAC_AUTO_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYC + 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_step_c;
    logic             held_c;

    // Continuous hold of exactly one setpoint button past its press edge
    assign held_c = (bus.button_up & ~bus.button_down & btn_q[1]) |
                    (bus.button_down & ~bus.button_up & btn_q[0]);

    always_comb begin
        rep_d      = '0;
        rep_step_c = 1'b0;
        if (held_c) begin
            if (rep_q == REP_W'(REPEAT_CYC - 1)) begin
                rep_step_c = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rep_q <= '0;
        else        rep_q <= rep_d;
    end

    assign up_evt_c = up_press_c | (rep_step_c & bus.button_up);
    assign dn_evt_c = dn_press_c | (rep_step_c & bus.button_down);
`else
    assign up_evt_c = up_press_c;
    assign dn_evt_c = dn_press_c;
`endif

    assign diff_c = $signed({1'b0, bus.temperature}) - $signed({1'b0, setpoint_q});
    assign diff_i = int'(diff_c);
    assign mag_i  = (diff_i < 0) ? -diff_i : diff_i;

    // Mode cycling and saturating setpoint
    always_comb begin
        mode_d     = mode_q;
        setpoint_d = setpoint_q;
        if (mode_q > MODE_HEAT) begin
            mode_d = MODE_OFF;
        end else if (mode_press_c) begin
            mode_d = mode_next(mode_q);
        end
        if (up_evt_c && !dn_evt_c && (setpoint_q < TEMP_W'(SET_MAX))) begin
            setpoint_d = setpoint_q + TEMP_W'(1);
        end else if (dn_evt_c && !up_evt_c && (setpoint_q > TEMP_W'(SET_MIN))) begin
            setpoint_d = setpoint_q - TEMP_W'(1);
        end
    end

    always_comb begin
        cool_req_c  = 1'b0;
        cool_mode_c = 1'b0;
        case (mode_q)
            MODE_AUTO:      begin cool_mode_c = 1'b1; cool_req_c = (diff_i > HYST_I);     end
            MODE_FAST_COOL: begin cool_mode_c = 1'b1; cool_req_c = (diff_i > 0);          end
            MODE_ECO:       begin cool_mode_c = 1'b1; cool_req_c = (diff_i > 2 * HYST_I); end
            default:        begin cool_mode_c = 1'b0; cool_req_c = 1'b0;                  end
        endcase
        heat_mode_c = (mode_q == MODE_AUTO) || (mode_q == MODE_HEAT);
        heat_req_c  = heat_mode_c && (diff_i < -HYST_I);
    end

    // Demand FSM; leaving COOL arms the compressor min-off timer
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;
        case (state_q)
            DEM_IDLE: begin
                if (cool_req_c && !lock_q) state_d = DEM_COOL;
                else if (heat_req_c)       state_d = DEM_HEAT;
            end
            DEM_COOL: begin
                if ((diff_i <= 0) || !cool_mode_c) begin
                    state_d = DEM_IDLE;
                    timer_d = TMR_W'(MIN_OFF_CYC);
                end
            end
            DEM_HEAT: begin
                if ((diff_i >= 0) || !heat_mode_c) state_d = DEM_IDLE;
            end
            default: state_d = DEM_IDLE;
        endcase
        comp_d = (state_d == DEM_COOL);
        heat_d = (state_d == DEM_HEAT);
        lock_d = (timer_d != '0);
    end

    always_comb begin
        fan_tgt_i = 0;
        case (mode_q)
            MODE_FAST_COOL: fan_tgt_i = FAN_LEVELS;
            MODE_ECO,
            MODE_HEAT:      fan_tgt_i = (state_q != DEM_IDLE) ? 1 : 0;
            MODE_AUTO: begin
                if      (mag_i <= HYST_I)         fan_tgt_i = 0;
                else if (mag_i <= int'(FAN_BAND1)) fan_tgt_i = 1;
                else if (mag_i <= int'(FAN_BAND2)) fan_tgt_i = 2;
                else if (mag_i <= int'(FAN_BAND3)) fan_tgt_i = 3;
                else                               fan_tgt_i = FAN_LEVELS;
            end
            default:        fan_tgt_i = 0;
        endcase
        if (fan_tgt_i > FAN_LEVELS) fan_tgt_i = FAN_LEVELS;
        fan_tgt_c = FAN_W'(fan_tgt_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q     <= MODE_OFF;
            setpoint_q <= TEMP_W'(SET_INIT);
            state_q    <= DEM_IDLE;
            timer_q    <= '0;
            comp_q     <= 1'b0;
            heat_q     <= 1'b0;
            lock_q     <= 1'b0;
            btn_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            setpoint_q <= setpoint_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            comp_q     <= comp_d;
            heat_q     <= heat_d;
            lock_q     <= lock_d;
            btn_q      <= btn_d;
        end
    end

    hvac_fan_ramp #(
        .FAN_W    (FAN_W),
        .RAMP_CYC (RAMP_CYC)
    ) u_fan_ramp (
        .clk    (clk),
        .rst_n  (reset),
        .target (fan_tgt_c),
        .level  (fan_level)
    );

    assign bus.mode          = mode_q;
    assign bus.setpoint      = setpoint_q;
    assign bus.fan_speed     = fan_level;
    assign bus.compressor_on = comp_q;
    assign bus.heater_on     = heat_q;
    assign bus.lockout       = lock_q;

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Self-checking bench for hvac_zone_ctrl: vector table, corner sequences, random vs model.
module tb_hvac_zone_ctrl;
    localparam int SET_MIN    = 18;
    localparam int SET_MAX    = 26;
    localparam int SET_INIT   = 22;
    localparam int HYST       = 1;
    localparam int FAN_LEVELS = 4;
    localparam int RAMP_CYC   = 4;
    localparam int MIN_OFF    = 16;
    localparam int REPEAT_CYC = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       b_mode = 1'b0, b_up = 1'b0, b_dn = 1'b0;
    logic [6:0] temp = 7'd22;

    int n_checks = 0;
    int n_errors = 0;

    hvac_zone_ctrl_if #(.TEMP_W(7), .FAN_W(3)) bus ();

    assign bus.button_mode = b_mode;
    assign bus.button_up   = b_up;
    assign bus.button_down = b_dn;
    assign bus.temperature = temp;

    hvac_zone_ctrl #(
        .TEMP_W(7), .SET_MIN(SET_MIN), .SET_MAX(SET_MAX), .SET_INIT(SET_INIT),
        .HYST(HYST), .FAN_LEVELS(FAN_LEVELS), .RAMP_CYC(RAMP_CYC), .MIN_OFF_CYC(MIN_OFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at negedge; outputs are sampled at the following negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: whole-number rules applied once per clock
    int m_mode, m_sp, m_fan, m_run, m_st, m_tmr, m_rep;
    bit pm, pu, pd;

    task automatic model_reset();
        m_mode = 0; m_sp = SET_INIT; m_fan = 0; m_run = 0;
        m_st = 0; m_tmr = 0; m_rep = 0; pm = 0; pu = 0; pd = 0;
    endtask

    task automatic model_step();
        int  diff, mag, tgt, nst, ntmr;
        bit  up_e, dn_e, cool, heat, coolm, heatm;
        int  bands[8] = '{0, 1, 1, 1, 2, 2, 3, 3};
        diff = int'(temp) - m_sp;
        mag  = (diff < 0) ? -diff : diff;
        case (m_mode)
            1:       tgt = (mag <= HYST) ? 0 : (mag <= 7) ? bands[mag] : FAN_LEVELS;
            2:       tgt = FAN_LEVELS;
            3, 4:    tgt = (m_st != 0) ? 1 : 0;
            default: tgt = 0;
        endcase
        if (tgt > FAN_LEVELS) tgt = FAN_LEVELS;
        coolm = (m_mode >= 1 && m_mode <= 3);
        heatm = (m_mode == 1 || m_mode == 4);
        cool  = (m_mode == 1 && diff > HYST) || (m_mode == 2 && diff > 0) ||
                (m_mode == 3 && diff > 2 * HYST);
        heat  = heatm && (diff < -HYST);
        nst  = m_st;
        ntmr = (m_tmr > 0) ? m_tmr - 1 : 0;
        if (m_st == 0) begin
            if (cool && m_tmr == 0) nst = 1;
            else if (heat)          nst = 2;
        end else if (m_st == 1) begin
            if (diff <= 0 || !coolm) begin nst = 0; ntmr = MIN_OFF; end
        end else begin
            if (diff >= 0 || !heatm) nst = 0;
        end
        if (m_fan == tgt) m_run = 0;
        else begin
            m_run++;
            if (m_run == RAMP_CYC) begin
                m_fan += (tgt > m_fan) ? 1 : -1;
                m_run = 0;
            end
        end
        up_e = b_up && !pu;
        dn_e = b_dn && !pd;
`ifdef HVAC_AUTO_REPEAT_EN
        if ((b_up ^ b_dn) && ((b_up && pu) || (b_dn && pd))) begin
            m_rep++;
            if (m_rep == REPEAT_CYC) begin
                m_rep = 0;
                if (b_up) up_e = 1; else dn_e = 1;
            end
        end else m_rep = 0;
`endif
        if (b_mode && !pm) m_mode = (m_mode + 1) % 5;
        if (up_e && !dn_e && m_sp < SET_MAX) m_sp++;
        else if (dn_e && !up_e && m_sp > SET_MIN) m_sp--;
        pm = b_mode; pu = b_up; pd = b_dn;
        m_st = nst; m_tmr = ntmr;
    endtask

    task automatic do_reset();
        reset = 1'b0; b_mode = 0; b_up = 0; b_dn = 0; temp = 7'd22;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit bm, bu, bd;
        int exp_mode, exp_sp;
    } vec_t;

    vec_t tbl[19];
    bit   hit;

    initial begin
        tbl[0]  = '{0, 1, 0, 0, 23};  tbl[1]  = '{0, 0, 0, 0, 23};
        tbl[2]  = '{0, 1, 0, 0, 24};  tbl[3]  = '{0, 0, 0, 0, 24};
        tbl[4]  = '{0, 1, 1, 0, 24};  tbl[5]  = '{0, 0, 0, 0, 24};
        tbl[6]  = '{0, 0, 1, 0, 23};  tbl[7]  = '{0, 0, 1, 0, 23};
        tbl[8]  = '{0, 0, 0, 0, 23};  tbl[9]  = '{1, 0, 0, 1, 23};
        tbl[10] = '{0, 0, 0, 1, 23};  tbl[11] = '{1, 0, 0, 2, 23};
        tbl[12] = '{0, 0, 0, 2, 23};  tbl[13] = '{1, 0, 0, 3, 23};
        tbl[14] = '{0, 0, 0, 3, 23};  tbl[15] = '{1, 0, 0, 4, 23};
        tbl[16] = '{1, 0, 0, 4, 23};  tbl[17] = '{0, 0, 0, 4, 23};
        tbl[18] = '{1, 0, 0, 0, 23};

        // Reset values while reset is held
        @(negedge clk);
        @(negedge clk);
        chk("rst_mode", bus.mode, 0);
        chk("rst_sp", bus.setpoint, SET_INIT);
        chk("rst_fan", bus.fan_speed, 0);
        chk("rst_comp", bus.compressor_on, 0);
        chk("rst_heat", bus.heater_on, 0);
        chk("rst_lock", bus.lockout, 0);

        // Vector table: buttons, expected mode/setpoint, no demand at diff -1
        do_reset();
        for (int i = 0; i < 19; i++) begin
            b_mode = tbl[i].bm; b_up = tbl[i].bu; b_dn = tbl[i].bd;
            tick();
            chk($sformatf("tbl%0d_mode", i), bus.mode, tbl[i].exp_mode);
            chk($sformatf("tbl%0d_sp", i), bus.setpoint, tbl[i].exp_sp);
            chk($sformatf("tbl%0d_comp", i), bus.compressor_on, 0);
            chk($sformatf("tbl%0d_heat", i), bus.heater_on, 0);
        end
        b_mode = 0;

        // Mode hold gives one advance; setpoint saturation both ways
        do_reset();
        b_mode = 1;
        for (int i = 0; i < 10; i++) begin tick(); chk("hold_mode", bus.mode, 1); end
        b_mode = 0; tick(); chk("hold_mode_rel", bus.mode, 1);
        for (int i = 0; i < 10; i++) begin
            b_up = 1; tick();
            chk($sformatf("up%0d", i), bus.setpoint, (23 + i > SET_MAX) ? SET_MAX : 23 + i);
            b_up = 0; tick();
        end
        for (int i = 0; i < 9; i++) begin
            b_dn = 1; tick();
            chk($sformatf("dn%0d", i), bus.setpoint, (25 - i < SET_MIN) ? SET_MIN : 25 - i);
            b_dn = 0; tick();
        end

        // AUTO cooling, fan ramp, then min-off lockout
        do_reset();
        b_mode = 1; tick(); b_mode = 0; tick();
        temp = 7'd30;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) chk("cool_on", bus.compressor_on, 1);
            chk($sformatf("ramp_k%0d", k), bus.fan_speed, k / 4);
        end
        temp = 7'd22;
        tick();
        chk("cool_off", bus.compressor_on, 0);
        chk("lock_start", bus.lockout, 1);
        for (int k = 2; k <= 18; k++) begin
            if (k == 5) temp = 7'd25;
            tick();
            chk($sformatf("lock_k%0d", k), bus.lockout, (k <= 16) ? 1 : 0);
            chk($sformatf("lock_comp_k%0d", k), bus.compressor_on, (k >= 18) ? 1 : 0);
        end

        // AUTO heating, then swing to cooling through IDLE
        do_reset();
        b_mode = 1; tick(); b_mode = 0; tick();
        temp = 7'd19;
        tick();
        chk("heat_on", bus.heater_on, 1);
        chk("heat_comp", bus.compressor_on, 0);
        repeat (3) tick();
        chk("heat_fan", bus.fan_speed, 1);
        repeat (4) tick();
        chk("heat_fan_hold", bus.fan_speed, 1);
        temp = 7'd26;
        tick();
        chk("swing_heat", bus.heater_on, 0);
        chk("swing_idle", bus.compressor_on, 0);
        tick();
        chk("swing_cool", bus.compressor_on, 1);
        chk("swing_heat2", bus.heater_on, 0);

        // Asynchronous reset in the middle of a fan ramp
        do_reset();
        b_mode = 1; tick(); b_mode = 0; tick();
        b_mode = 1; tick(); b_mode = 0; tick();
        temp = 7'd30;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (bus.fan_speed == 2) hit = 1;
        end
        chk("midramp_reached", int'(hit), 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_mode", bus.mode, 0);
        chk("arst_sp", bus.setpoint, SET_INIT);
        chk("arst_fan", bus.fan_speed, 0);
        chk("arst_comp", bus.compressor_on, 0);
        chk("arst_heat", bus.heater_on, 0);
        chk("arst_lock", bus.lockout, 0);

`ifdef HVAC_AUTO_REPEAT_EN
        // Hold-to-repeat: one press step plus one per REPEAT_CYC held cycles
        do_reset();
        b_up = 1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 32) chk("rep_k32", bus.setpoint, 23);
            if (k == 33) chk("rep_k33", bus.setpoint, 24);
        end
        chk("rep_total", bus.setpoint, 26);
        b_up = 0; tick();
`endif

        // Random stimulus against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) b_mode = ~b_mode;
            if ($urandom_range(0, 3) == 0) b_up = ~b_up;
            if ($urandom_range(0, 3) == 0) b_dn = ~b_dn;
            if ($urandom_range(0, 5) == 0) temp = 7'($urandom_range(14, 34));
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("rnd_mode", bus.mode, m_mode);
            chk("rnd_sp", bus.setpoint, m_sp);
            chk("rnd_fan", bus.fan_speed, m_fan);
            chk("rnd_comp", bus.compressor_on, (m_st == 1) ? 1 : 0);
            chk("rnd_heat", bus.heater_on, (m_st == 2) ? 1 : 0);
            chk("rnd_lock", bus.lockout, (m_tmr != 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
